// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter.
// Address map, slave select bit positions and FSM states.
package bus_pkg;

    localparam logic [31:0] RAM_BASE     = 32'd256;
    localparam logic [31:0] RAM_SIZE     = 32'd256;
    localparam logic [31:0] LED_ADDR     = 32'd1024;
    localparam logic [31:0] UART_TX_ADDR = 32'd1028;
    localparam logic [31:0] UART_RX_ADDR = 32'd1032;

    localparam int SEL_RAM     = 0;
    localparam int SEL_LED     = 1;
    localparam int SEL_UART_TX = 2;
    localparam int SEL_UART_RX = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR
    } state_t;

endpackage

// File: rtl/addr_decode.sv
// Combinational address decoder for the bus arbiter.
// Produces a one-hot slave select and a mapped flag.
module addr_decode
    import bus_pkg::*;
(
    input  logic [31:0] addr,
    output logic [3:0]  sel,
    output logic        mapped
);

    logic in_ram;

    assign in_ram = (addr >= RAM_BASE)
                 && (addr < RAM_BASE + RAM_SIZE);

    // Map the address onto exactly one slave, or none.
    always_comb begin
        sel = '0;
        unique case (1'b1)
            in_ram:                 sel[SEL_RAM]     = 1'b1;
            (addr == LED_ADDR):     sel[SEL_LED]     = 1'b1;
            (addr == UART_TX_ADDR): sel[SEL_UART_TX] = 1'b1;
            (addr == UART_RX_ADDR): sel[SEL_UART_RX] = 1'b1;
            default: ;
        endcase
    end

    assign mapped = |sel;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, single-slave-port bus arbiter with round-robin
// contention, address decode, slave timeout and error counting.
module bus_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_en,
    input  logic        m0_read,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_en,
    input  logic        m1_read,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        s_en,
    output logic        s_read,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_sel,
    input  logic [31:0] s_rdata,
    input  logic        s_ack,
    output logic [7:0]  err_count
);
    import bus_pkg::*;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t        state;
    logic          owner;
    logic          last_owner;
    logic [TW-1:0] tcnt;

    logic          grant;
    logic          win;
    logic [31:0]   win_addr;
    logic [3:0]    win_sel;
    logic          win_mapped;
    logic [7:0]    err_next;

    // Pick the winner; the ack cycle is kept as a mandatory idle gap.
    always_comb begin
        grant = (m0_en | m1_en) & ~(m0_ack | m1_ack);
        win   = 1'b0;
        if (m0_en && m1_en) begin
            win = ~last_owner;
        end else if (m1_en) begin
            win = 1'b1;
        end
        win_addr = win ? m1_addr : m0_addr;
        err_next = (err_count == 8'hFF) ? err_count
                                        : err_count + 8'd1;
    end

    addr_decode u_dec (
        .addr   (win_addr),
        .sel    (win_sel),
        .mapped (win_mapped)
    );

    // Arbitration FSM with registered slave strobes and responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            tcnt       <= '0;
            s_en       <= 1'b0;
            s_read     <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_sel      <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            err_count  <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner   <= win;
                        s_read  <= win ? m1_read : m0_read;
                        s_addr  <= win_addr;
                        s_wdata <= win ? m1_wdata : m0_wdata;
                        s_sel   <= win_sel;
                        tcnt    <= '0;
                        if (m0_en && m1_en) begin
                            last_owner <= win;
                        end
                        if (win_mapped) begin
                            s_en  <= 1'b1;
                            state <= BUSY;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    if (s_ack) begin
                        s_en  <= 1'b0;
                        s_sel <= '0;
                        state <= IDLE;
                        if (owner) begin
                            m1_ack <= 1'b1;
                            if (s_read) m1_rdata <= s_rdata;
                        end else begin
                            m0_ack <= 1'b1;
                            if (s_read) m0_rdata <= s_rdata;
                        end
                    end else if (tcnt == TMAX) begin
                        s_en      <= 1'b0;
                        s_sel     <= '0;
                        state     <= IDLE;
                        err_count <= err_next;
                        if (owner) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= 32'hFFFF_FFFF;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= 32'hFFFF_FFFF;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ERR: begin
                    state     <= IDLE;
                    err_count <= err_next;
                    if (owner) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= '0;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus
// randomized rounds against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_en, m0_read, m1_en, m1_read;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        s_en, s_read, s_ack;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_sel;
    logic [7:0]  err_count;

    int checks = 0;
    int passed = 0;

    // reference model state
    logic [31:0] m_rd [2];
    int          m_err;
    bit          m_last;
    bit          chaos;

    // per-master transaction descriptors
    bit          t_read  [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [31:0] t_sdata [2];
    int          t_delay [2];

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_en     (m0_en),
        .m0_read   (m0_read),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_en     (m1_en),
        .m1_read   (m1_read),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .s_en      (s_en),
        .s_read    (s_read),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_sel     (s_sel),
        .s_rdata   (s_rdata),
        .s_ack     (s_ack),
        .err_count (err_count)
    );

    function automatic logic [3:0] spec_sel(logic [31:0] a);
        if (a >= 32'd256 && a < 32'd512) return 4'b0001;
        if (a == 32'd1024) return 4'b0010;
        if (a == 32'd1028) return 4'b0100;
        if (a == 32'd1032) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic model_reset;
        m_rd[0] = '0;
        m_rd[1] = '0;
        m_err   = 0;
        m_last  = 1'b1;
    endtask

    task automatic apply_reset;
        rst   = 1'b1;
        m0_en = 1'b0;
        m1_en = 1'b0;
        s_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_txn(input int m, input bit rd,
                           input logic [31:0] a, input int d);
        t_read[m]  = rd;
        t_addr[m]  = a;
        t_wdata[m] = $urandom;
        t_sdata[m] = $urandom;
        t_delay[m] = d;
    endtask

    task automatic gen_txn(input int m);
        int c;
        c = $urandom_range(0, 8);
        t_read[m] = 1'($urandom_range(0, 1));
        case (c)
            0, 1:    t_addr[m] = 32'd256 + 32'($urandom_range(0, 255));
            2:       t_addr[m] = 32'd1024;
            3:       t_addr[m] = 32'd1028;
            4:       t_addr[m] = 32'd1032;
            5:       t_addr[m] = 32'd255;
            6:       t_addr[m] = 32'd512;
            7:       t_addr[m] = 32'd511;
            default: t_addr[m] = $urandom;
        endcase
        t_wdata[m] = $urandom;
        t_sdata[m] = $urandom;
        t_delay[m] = $urandom_range(0, TO + 1);
    endtask

    // One arbitration round: an idle cycle, then the requested masters
    // are served in the order the round-robin rule predicts.
    task automatic do_round(input bit e0, input bit e1);
        int order[$];
        int w;
        @(posedge clk); #1;
        s_ack = 1'b0;
        checks++;
        if ({m0_ack, m1_ack, s_en} !== 3'b000)
            $display("FAIL idle_gap: ack0,ack1,s_en=%b required 000",
                     {m0_ack, m1_ack, s_en});
        else passed++;
        if (e0 && e1) begin
            w = m_last ? 0 : 1;
            m_last = (w == 1);
            order.push_back(w);
            order.push_back(1 - w);
        end else if (e0) begin
            order.push_back(0);
        end else if (e1) begin
            order.push_back(1);
        end
        m0_en = e0; m0_read = t_read[0];
        m0_addr = t_addr[0]; m0_wdata = t_wdata[0];
        m1_en = e1; m1_read = t_read[1];
        m1_addr = t_addr[1]; m1_wdata = t_wdata[1];
        for (int k = 0; k < order.size(); k++) begin
            int m, cyc, n, exp_first, exp_n, exp_cyc;
            bit mapped, acked;
            logic got, oth;
            logic [3:0] esel;
            m = order[k];
            esel = spec_sel(t_addr[m]);
            mapped = (esel != 4'b0000);
            exp_first = (k == 0) ? 1 : 2;
            exp_n = !mapped ? 0
                  : (t_delay[m] < TO ? t_delay[m] + 1 : TO);
            exp_cyc = exp_first + (mapped ? exp_n : 1);
            n = 0;
            cyc = 0;
            acked = 1'b0;
            while (!acked && cyc < 60) begin
                @(posedge clk); #1;
                cyc++;
                s_ack = 1'b0;
                got = (m == 1) ? m1_ack : m0_ack;
                oth = (m == 1) ? m0_ack : m1_ack;
                checks++;
                if (oth !== 1'b0)
                    $display("FAIL other_ack: m%0d ack=%b required 0",
                             1 - m, oth);
                else passed++;
                if (got === 1'b1) begin
                    acked = 1'b1;
                    if (!mapped) begin
                        m_rd[m] = '0;
                        if (m_err < 255) m_err++;
                    end else if (t_delay[m] < TO) begin
                        if (t_read[m]) m_rd[m] = t_sdata[m];
                    end else begin
                        m_rd[m] = 32'hFFFF_FFFF;
                        if (m_err < 255) m_err++;
                    end
                    checks++;
                    if ({m0_rdata, m1_rdata} !== {m_rd[0], m_rd[1]})
                        $display("FAIL rdata: m0=%h m1=%h required %h %h",
                                 m0_rdata, m1_rdata, m_rd[0], m_rd[1]);
                    else passed++;
                    checks++;
                    if (err_count !== 8'(m_err))
                        $display("FAIL err_count: got %0d required %0d",
                                 err_count, m_err);
                    else passed++;
                    checks++;
                    if (n != exp_n || cyc != exp_cyc || s_en !== 1'b0)
                        $display("FAIL timing: m%0d en_cycles=%0d ack_cycle=%0d s_en=%b required %0d %0d 0",
                                 m, n, cyc, s_en, exp_n, exp_cyc);
                    else passed++;
                    if (m == 0) m0_en = 1'b0;
                    else m1_en = 1'b0;
                end else if (s_en === 1'b1) begin
                    n++;
                    checks++;
                    if (n == 1 && cyc != exp_first)
                        $display("FAIL grant_latency: s_en at %0d required %0d",
                                 cyc, exp_first);
                    else if ({s_read, s_sel, s_addr, s_wdata} !==
                             {t_read[m], esel, t_addr[m], t_wdata[m]})
                        $display("FAIL s_bus: rd=%b sel=%b addr=%h wd=%h required %b %b %h %h",
                                 s_read, s_sel, s_addr, s_wdata,
                                 t_read[m], esel, t_addr[m], t_wdata[m]);
                    else passed++;
                    if (n - 1 == t_delay[m]) begin
                        s_ack   = 1'b1;
                        s_rdata = t_sdata[m];
                    end else begin
                        s_rdata = $urandom;
                    end
                    if (chaos && $urandom_range(0, 3) == 0) begin
                        if (m == 0) m0_en = 1'b0;
                        else m1_en = 1'b0;
                    end
                end else if (chaos && $urandom_range(0, 2) == 0) begin
                    s_ack   = 1'b1;
                    s_rdata = $urandom;
                end
            end
            checks++;
            if (!acked)
                $display("FAIL no_ack: m%0d got no ack in %0d cycles",
                         m, cyc);
            else passed++;
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s_en, s_read, s_sel, m0_ack, m1_ack, s_addr, s_wdata,
             m0_rdata, m1_rdata, err_count} !== '0)
            $display("FAIL reset_async: outputs not cleared, err=%h s_en=%b",
                     err_count, s_en);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if ({s_en, s_sel, m0_ack, m1_ack, err_count} !== '0)
            $display("FAIL reset_held: s_en=%b sel=%b err=%h",
                     s_en, s_sel, err_count);
        else passed++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_read;
        apply_reset();
        set_txn(0, 1'b1, 32'd260, 2);
        t_sdata[0] = 32'hDEAD_BEEF;
        do_round(1'b1, 1'b0);
        checks++;
        if (m0_rdata !== 32'hDEAD_BEEF)
            $display("FAIL single_read: m0_rdata=%h required deadbeef",
                     m0_rdata);
        else passed++;
    endtask

    task automatic test_contention;
        apply_reset();
        set_txn(0, 1'b0, 32'd1024, 0);
        set_txn(1, 1'b1, 32'd300, 1);
        do_round(1'b1, 1'b1);
        set_txn(0, 1'b1, 32'd511, 0);
        set_txn(1, 1'b0, 32'd1028, 0);
        do_round(1'b1, 1'b1);
        set_txn(0, 1'b1, 32'd256, 3);
        set_txn(1, 1'b1, 32'd1032, 0);
        do_round(1'b1, 1'b1);
    endtask

    task automatic test_unmapped;
        apply_reset();
        set_txn(1, 1'b0, 32'd2048, 0);
        do_round(1'b0, 1'b1);
        checks++;
        if (err_count !== 8'd1 || m1_rdata !== 32'd0)
            $display("FAIL unmapped: err=%0d m1_rdata=%h required 1 0",
                     err_count, m1_rdata);
        else passed++;
    endtask

    task automatic test_timeout;
        apply_reset();
        set_txn(0, 1'b1, 32'd1032, 99);
        do_round(1'b1, 1'b0);
        checks++;
        if (m0_rdata !== 32'hFFFF_FFFF || err_count !== 8'd1)
            $display("FAIL timeout: m0_rdata=%h err=%0d required ffffffff 1",
                     m0_rdata, err_count);
        else passed++;
    endtask

    task automatic test_reset_mid_busy;
        apply_reset();
        m0_en = 1'b1; m0_read = 1'b1;
        m0_addr = 32'd300; m0_wdata = '0;
        @(posedge clk); #1;
        checks++;
        if (s_en !== 1'b1)
            $display("FAIL busy_entry: s_en=%b required 1", s_en);
        else passed++;
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({s_en, s_sel, m0_ack, m1_ack} !== 7'd0)
            $display("FAIL reset_mid_busy: s_en=%b sel=%b acks=%b%b required 0",
                     s_en, s_sel, m0_ack, m1_ack);
        else passed++;
        m0_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({m0_ack, m1_ack, s_en} !== 3'b000)
            $display("FAIL reset_no_ack: acks=%b%b s_en=%b required 0",
                     m0_ack, m1_ack, s_en);
        else passed++;
        rst = 1'b0;
        model_reset();
        set_txn(0, 1'b1, 32'd300, 0);
        set_txn(1, 1'b0, 32'd1024, 1);
        do_round(1'b1, 1'b1);
    endtask

    task automatic test_random;
        apply_reset();
        chaos = 1'b1;
        for (int r = 0; r < 80; r++) begin
            int p;
            gen_txn(0);
            gen_txn(1);
            p = $urandom_range(1, 3);
            do_round(p[0], p[1]);
        end
        chaos = 1'b0;
    endtask

    task automatic test_saturation;
        apply_reset();
        for (int i = 0; i < 260; i++) begin
            set_txn(1, 1'($urandom_range(0, 1)),
                    32'd2048 + 32'(i * 4), 0);
            do_round(1'b0, 1'b1);
        end
        checks++;
        if (err_count !== 8'd255)
            $display("FAIL saturation: err=%0d required 255", err_count);
        else passed++;
    endtask

    initial begin
        rst = 1'b0;
        chaos = 1'b0;
        m0_en = 1'b0; m0_read = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_en = 1'b0; m1_read = 1'b0; m1_addr = '0; m1_wdata = '0;
        s_ack = 1'b0; s_rdata = '0;
        model_reset();
        test_reset();
        test_single_read();
        test_contention();
        test_unmapped();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
